// File: rtl/hex_keypad_scanner_if.sv
// Keypad scanner bus: column drive and row sense, operand-clear input, key and operand outputs.
// Pure wiring; no storage or latency of its own.
// No backpressure: KEY_VALID and OPERAND_VALID are single-cycle pulses that are not held.
interface hex_keypad_scanner_if;
  logic [3:0] COL;
  logic [3:0] ROW;
  logic       CLEAR;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic [7:0] OPERAND;
  logic       OPERAND_VALID;

  // The scanner drives the columns and results, and samples rows and clear.
  modport master (
    output COL, KEY_CODE, KEY_VALID, OPERAND, OPERAND_VALID,
    input  ROW, CLEAR
  );

  // The keypad/consumer side drives the rows and clear.
  modport slave (
    input  COL, KEY_CODE, KEY_VALID, OPERAND, OPERAND_VALID,
    output ROW, CLEAR
  );
endinterface

// File: rtl/hex_keypad_scanner.sv
// 4x4 hex keypad scanner with debounce, ghost rejection and two-digit operand assembly.
// Latency: KEY_VALID is high the cycle after the accepting frame close; OPERAND_VALID follows one cycle later.
// No backpressure: outputs are single-cycle pulses, and the consumer must take them when they occur.
module hex_keypad_scanner #(
  parameter int SCAN_DIV       = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic             CLK,
  input logic             reset,
  hex_keypad_scanner_if.master bus
);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int N_W   = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;

  logic [3:0]       r_row_s1, r_row_s2;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [1:0]       r_col;
  logic [1:0]       r_acc_hits;   // pressed bits seen so far this frame, saturating at 2
  logic [3:0]       r_acc_code;

  logic             w_tick, w_frame_close;
  logic [3:0]       w_pressed;
  logic [1:0]       w_col_hits, w_col_row;
  logic [2:0]       w_sum;
  logic [1:0]       w_tot_hits;
  logic [3:0]       w_tot_code;
  logic             w_single;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_cand, w_cand_nxt;
  logic [N_W-1:0]   r_n, w_n_nxt;
  logic [3:0]       r_key_code, w_key_code_nxt;
  logic             r_key_vld, w_key_vld_nxt;

  logic [3:0]       r_hi;
  logic             r_digit;
  logic [7:0]       r_operand;
  logic             r_op_vld;

  assign w_tick        = (r_tick_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_frame_close = w_tick && (r_col == 2'd3);
  assign w_pressed     = ~r_row_s2;

  // Two-flop synchroniser for the asynchronous row inputs; idle rows read as pulled up.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= bus.ROW;
      r_row_s2 <= r_row_s1;
    end
  end

  // Column step timer and column index, advancing on each tick.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_col      <= 2'd0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
      r_col      <= r_col + 2'd1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // Count pressed rows in the current column and locate a lone one.
  always_comb begin
    w_col_hits = 2'd0;
    w_col_row  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (w_pressed[i]) begin
        if (w_col_hits != 2'd2) w_col_hits = w_col_hits + 2'd1;
        w_col_row = 2'(i);
      end
    end
    w_sum      = {1'b0, r_acc_hits} + {1'b0, w_col_hits};
    w_tot_hits = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_tot_code = (w_col_hits == 2'd1) ? {w_col_row, r_col} : r_acc_code;
    w_single   = (w_tot_hits == 2'd1);
  end

  // Accumulate column samples across a frame; clear at frame close.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_acc_hits <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_frame_close) begin
      r_acc_hits <= 2'd0;
      r_acc_code <= 4'd0;
    end else if (w_tick) begin
      r_acc_hits <= w_tot_hits;
      r_acc_code <= w_tot_code;
    end
  end

  // Debounce state register and registered key outputs.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cand     <= 4'd0;
      r_n        <= '0;
      r_key_code <= 4'd0;
      r_key_vld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cand     <= w_cand_nxt;
      r_n        <= w_n_nxt;
      r_key_code <= w_key_code_nxt;
      r_key_vld  <= w_key_vld_nxt;
    end
  end

  // Debounce next-state logic; only frame closes move the machine.
  always_comb begin
    w_state_nxt    = r_state;
    w_cand_nxt     = r_cand;
    w_n_nxt        = r_n;
    w_key_code_nxt = r_key_code;
    w_key_vld_nxt  = 1'b0;
    if (w_frame_close) begin
      case (r_state)
        IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_tot_code;
            w_n_nxt    = N_W'(1);
            if (DEBOUNCE_SCANS <= 1) begin
              w_state_nxt    = HELD;
              w_key_code_nxt = w_tot_code;
              w_key_vld_nxt  = 1'b1;
            end else begin
              w_state_nxt = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (w_single && (w_tot_code == r_cand)) begin
            w_n_nxt = r_n + 1'b1;
            if (int'(r_n) + 1 >= DEBOUNCE_SCANS) begin
              w_state_nxt    = HELD;
              w_key_code_nxt = r_cand;
              w_key_vld_nxt  = 1'b1;
            end
          end else if (w_single) begin
            w_cand_nxt = w_tot_code;
            w_n_nxt    = N_W'(1);
          end else begin
            w_state_nxt = IDLE;
          end
        end
        HELD: begin
          // A single release frame is already a full release when one scan suffices.
          if (!(w_single && (w_tot_code == r_cand))) begin
            w_n_nxt     = N_W'(1);
            w_state_nxt = (DEBOUNCE_SCANS <= 1) ? IDLE : RELEASE;
          end
        end
        RELEASE: begin
          if (w_single) begin
            w_state_nxt = HELD;
          end else begin
            w_n_nxt = r_n + 1'b1;
            if (int'(r_n) + 1 >= DEBOUNCE_SCANS) w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Two-digit operand assembly; CLEAR overrides a coincident key.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      r_hi      <= 4'd0;
      r_digit   <= 1'b0;
      r_operand <= 8'd0;
      r_op_vld  <= 1'b0;
    end else begin
      r_op_vld <= 1'b0;
      if (bus.CLEAR) begin
        r_hi    <= 4'd0;
        r_digit <= 1'b0;
      end else if (r_key_vld) begin
        if (!r_digit) begin
          r_hi    <= r_key_code;
          r_digit <= 1'b1;
        end else begin
          r_operand <= {r_hi, r_key_code};
          r_digit   <= 1'b0;
          r_op_vld  <= 1'b1;
        end
      end
    end
  end

  assign bus.COL           = ~(4'b0001 << r_col);
  assign bus.KEY_CODE      = r_key_code;
  assign bus.KEY_VALID     = r_key_vld;
  assign bus.OPERAND       = r_operand;
  assign bus.OPERAND_VALID = r_op_vld;
endmodule
